pc_fetch_unit: RTL

Program-counter and instruction-fetch stage of the MIPS core, sitting directly downstream of the 16→32-bit immediate sign extender. It consumes the sign-extended branch offset to form branch targets and holds the PC register. It fetches each instruction from instruction memory with a request/valid handshake, then holds the instruction for the datapath until the datapath advances.

---
 rtl/pc_fetch_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and request/valid instruction fetch stage
// Optional MISALIGN_CHECK_EN: trap misaligned JR targets into a sticky flag.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] extended_constant,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        advance,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] next_pc;
  logic        pc_load;
  logic        capture;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign pc_load   = (state == HOLD) && advance && !stall;
  assign capture   = (state == WAIT) && imem_valid;

`ifdef MISALIGN_CHECK_EN
  logic jr_misaligned;
  assign jr_misaligned = jr && (jr_target[1:0] != 2'b00);
`endif

  // Target select: jr > jump > branch > sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
`ifdef MISALIGN_CHECK_EN
      next_pc = jr_misaligned ? pc_plus4 : (jr_target & 32'hFFFF_FFFC);
`else
      next_pc = jr_target & 32'hFFFF_FFFC;
`endif
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + (extended_constant << 2);
    end
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req   = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (imem_valid) state_next = HOLD;
      HOLD: if (advance && !stall) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      instr_valid <= (state_next == HOLD);
      if (capture) instr <= imem_rdata;
      if (pc_load) pc <= next_pc;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) misaligned <= 1'b0;
    else if (pc_load && jr_misaligned) misaligned <= 1'b1;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule
